// File: rtl/d_p_mem_arbiter.sv
// d_p_mem_arbiter: round-robin arbiter and sequencer for a 16x4 dual-port memory.
// Grants up to two accesses per cycle (at most one write) and returns responses two cycles later.
`default_nettype none

module d_p_mem_arbiter #(
   parameter int NREQ    = 4,
   parameter int DEFER_W = 8
) (
   input  logic                clk,
   input  logic                reset_n,
   input  logic [NREQ-1:0]     req,
   input  logic [NREQ-1:0]     req_we,
   input  logic [4*NREQ-1:0]   req_addr,
   input  logic [4*NREQ-1:0]   req_wdata,
   output logic [NREQ-1:0]     gnt,
   output logic [NREQ-1:0]     rsp_valid,
   output logic [4*NREQ-1:0]   rsp_data,
   output logic                mem_we_0,
   output logic                mem_we_1,
   output logic [3:0]          mem_addr_0,
   output logic [3:0]          mem_addr_1,
   output logic [3:0]          mem_wdata_0,
   output logic [3:0]          mem_wdata_1,
   input  logic [3:0]          mem_rdata_0,
   input  logic [3:0]          mem_rdata_1,
   output logic [DEFER_W-1:0]  defer_cnt
);

   logic [1:0]      ptr;
   logic [1:0]      a_id;
   logic [1:0]      b_id;
   logic [1:0]      idx;
   logic            a_vld;
   logic            b_vld;
   logic            next_seen;
   logic            defer;
   logic [1:0]      s1_vld;
   logic [1:0]      s2_vld;
   logic [1:0][1:0] s1_id;
   logic [1:0][1:0] s2_id;

   // A write counts as deferred only when it is the very next requester after a writing slot A.
   always_comb begin
      a_vld     = 1'b0;
      b_vld     = 1'b0;
      a_id      = ptr;
      b_id      = ptr;
      idx       = ptr;
      next_seen = 1'b0;
      defer     = 1'b0;
      for (int i = 0; i < 4; i++) begin
         idx = ptr + 2'(i);
         if (req[idx]) begin
            if (!a_vld) begin
               a_vld = 1'b1;
               a_id  = idx;
            end else begin
               if (!next_seen && req_we[a_id] && req_we[idx]) defer = 1'b1;
               next_seen = 1'b1;
               if (!b_vld && !(req_we[a_id] && req_we[idx])) begin
                  b_vld = 1'b1;
                  b_id  = idx;
               end
            end
         end
      end
   end

   always_comb begin
      gnt = '0;
      if (reset_n) begin
         if (a_vld) gnt[a_id] = 1'b1;
         if (b_vld) gnt[b_id] = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         ptr         <= '0;
         mem_we_0    <= 1'b0;
         mem_we_1    <= 1'b0;
         mem_addr_0  <= '0;
         mem_addr_1  <= '0;
         mem_wdata_0 <= '0;
         mem_wdata_1 <= '0;
         s1_vld      <= '0;
         s2_vld      <= '0;
         s1_id       <= '0;
         s2_id       <= '0;
         rsp_valid   <= '0;
         rsp_data    <= '0;
         defer_cnt   <= '0;
      end else begin
         mem_we_0 <= a_vld && req_we[a_id];
         mem_we_1 <= b_vld && req_we[b_id];
         if (a_vld) begin
            mem_addr_0  <= req_addr[{a_id, 2'b00} +: 4];
            mem_wdata_0 <= req_wdata[{a_id, 2'b00} +: 4];
         end
         if (b_vld) begin
            mem_addr_1  <= req_addr[{b_id, 2'b00} +: 4];
            mem_wdata_1 <= req_wdata[{b_id, 2'b00} +: 4];
         end

         if (b_vld)      ptr <= b_id + 2'd1;
         else if (a_vld) ptr <= a_id + 2'd1;

         s1_vld <= {b_vld, a_vld};
         s1_id  <= {b_id, a_id};
         s2_vld <= s1_vld;
         s2_id  <= s1_id;

         // Both ports come from the same grant cycle, so their ids never collide.
         rsp_valid <= '0;
         if (s2_vld[0]) begin
            rsp_valid[s2_id[0]]               <= 1'b1;
            rsp_data[{s2_id[0], 2'b00} +: 4]  <= mem_rdata_0;
         end
         if (s2_vld[1]) begin
            rsp_valid[s2_id[1]]               <= 1'b1;
            rsp_data[{s2_id[1], 2'b00} +: 4]  <= mem_rdata_1;
         end

         if (defer && (defer_cnt != '1)) defer_cnt <= defer_cnt + 1'b1;
      end
   end

endmodule

`default_nettype wire

// File: doc/d_p_mem_arbiter.md
# d_p_mem_arbiter

Four-requester round-robin arbiter and sequencer for the 16x4 dual-port data memory (`d_p_mem`). Each cycle it grants up to two requests, one per memory port, and drives the memory's port signals from flops. It enforces at most one write per cycle. It returns read data, and write acknowledges, to the owning requester at a fixed latency.

## Interface
- NREQ, 4: number of requesters; fixed at 4, with 2-bit requester IDs.
- DEFER_W, 8: width of the saturating write-defer counter.

- clk  in  1  clock
- reset_n  in  1  reset reset_n, asynchronous, active-low; clock clk
- req  in  4  per-requester request; held until granted
- req_we  in  4  per-requester write enable (1 = write, 0 = read)
- req_addr  in  16  per-requester 4-bit address; requester i uses bits [4i+3:4i]
- req_wdata  in  16  per-requester 4-bit write data, same packing as req_addr
- gnt  out  4  combinational grant; request i is accepted at the rising edge where req[i] and gnt[i] are both 1
- rsp_valid  out  4  one-cycle response strobe per requester
- rsp_data  out  16  per-requester 4-bit response data
- mem_we_0, mem_we_1  out  1  to memory wE_0/wE_1
- mem_addr_0, mem_addr_1  out  4  to memory Addr_0/Addr_1
- mem_wdata_0, mem_wdata_1  out  4  to memory WrData_0/WrData_1
- mem_rdata_0, mem_rdata_1  in  4  from memory RdData_0/RdData_1
- defer_cnt  out  DEFER_W  count of cycles in which a write was refused solely by the one-write rule; saturates at all-ones

## Operation
- Round-robin pointer `ptr` (2 bits) is the requester with highest priority. Requesters are scanned in order ptr, ptr+1, ptr+2, ptr+3 (mod 4).
- Slot A (memory port 0) goes to the first requester with req=1.
- Slot B (memory port 1) goes to the next requester with req=1, skipping any write requester if slot A holds a write.
- Never more than one write per cycle. Never more than two grants per cycle. A requester is never granted twice in one cycle.
- A write refused only because slot A already holds a write increments defer_cnt once for that cycle.
- Pointer update on a cycle with any grant: ptr <= (last granted index + 1) mod 4. With no grant, ptr holds.
- Flop memory-port outputs on each accepting edge:
  - Granted slot: mem_we = req_we, plus address and write data of the grantee.
  - Empty slot: mem_we = 0; address and write data hold their previous values.
- Response tag pipeline, 2 stages per port: {valid, id}. At stage 2, rsp_data[id] <= mem_rdata of that port and rsp_valid[id] <= 1.
- Writes also respond: rsp_data carries the written value, because the memory read is write-first.
- rsp_valid bits are 1-cycle pulses. Unaffected requesters keep rsp_data unchanged.
- Ordering: an access accepted at edge k observes every write accepted at edge k-1 or earlier.
- A read and a write to the same address in the same cycle are legal; the read returns the new data.

## Timing
- Acceptance at edge k. Memory-port flops update at edge k. The memory captures at edge k+1. rsp_valid/rsp_data update at edge k+2. Latency is 2 cycles, and throughput is 2 accesses per cycle.
- gnt depends combinationally on req, req_we and ptr only, with no dependence on req_addr. It is forced to 0 while reset_n=0.
- Reset values:
  - gnt, rsp_valid: 0
  - rsp_data: 0
  - mem_we_*, mem_addr_*, mem_wdata_*: 0
  - ptr: 0; tag pipeline valid bits: 0
  - defer_cnt: 0
- Reset asserted mid-operation: all in-flight tags are dropped and no rsp_valid is produced for them. Writes already flopped to the memory ports are not guaranteed to complete.
- Boundary conditions:
  - req = 0: no grants; ptr holds; memory we = 0.
  - All 4 requesting: exactly 2 grants.
  - ptr = 3: the scan wraps to 0.
  - defer_cnt at all-ones: holds its value.

## Test plan
- Reset, then reqs idle for 5 cycles: all outputs 0, defer_cnt = 0, mem_we_* = 0.
- Requester 1 writes addr 5 = 4'hA (accepted edge 0); requester 2 then reads addr 5 (accepted edge 1): rsp_valid[1] at edge 2 with data A; rsp_valid[2] at edge 3 with data A.
- All 4 hold reads of addrs 0-3, ptr = 0: grants {0,1}, then {2,3}. Responses at edges 2, 2, 3, 3 with the preloaded values.
- Requesters 0 and 3 both write, ptr = 0: the first cycle grants only 0 and defer_cnt becomes 1. Requester 3 is granted next cycle, and mem_we_0 and mem_we_1 are never both 1.
- ptr = 3, requesters 0 and 3 read: slot A = 3, slot B = 0, and next ptr = 1.
- Write + read of addr 7 in the same cycle (write to 4'h6): the read response is 6. Then assert reset_n = 0 with 2 accesses in flight: no rsp_valid, and all outputs are at reset values.
